// File: rtl/regbank_sb.sv
// Register bank with two bypassed async read ports, ALU (A) and load (B) write ports,
// and a per-register load-pending scoreboard; reads are 0-cycle, state updates on clk.
module regbank_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic              o_rd_busy1,
  output logic              o_rd_busy2,
  input  logic              i_wa_en,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [DATA_W-1:0] i_wa_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_mark_en,
  input  logic [ADDR_W-1:0] i_mark_addr,
  output logic [ADDR_W:0]   o_pending_cnt,
  output logic [1:0]        o_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [ADDR_W:0]   r_pending_cnt;
  logic [1:0]        r_err;

  logic              w_wa_ok;
  logic              w_wb_ok;
  logic              w_mark_ok;
  logic              w_ab_clash;
  logic              w_cnt_inc;
  logic              w_cnt_dec;
  logic [DEPTH-1:0]  w_pending_nxt;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Accesses to a hardwired r0 are squashed up front so they touch neither data, pending nor err.
  assign w_wa_ok    = i_wa_en   & ~is_zero(i_wa_addr);
  assign w_wb_ok    = i_wb_en   & ~is_zero(i_wb_addr);
  assign w_mark_ok  = i_mark_en & ~is_zero(i_mark_addr);
  assign w_ab_clash = w_wa_ok & w_wb_ok & (i_wa_addr == i_wb_addr);

  always_comb begin
    o_rd_data1 = r_mem[i_rd_addr1];
    if (i_wb_en && (i_wb_addr == i_rd_addr1))
      o_rd_data1 = i_wb_data;
    else if (i_wa_en && (i_wa_addr == i_rd_addr1))
      o_rd_data1 = i_wa_data;
    if (is_zero(i_rd_addr1))
      o_rd_data1 = '0;
  end

  always_comb begin
    o_rd_data2 = r_mem[i_rd_addr2];
    if (i_wb_en && (i_wb_addr == i_rd_addr2))
      o_rd_data2 = i_wb_data;
    else if (i_wa_en && (i_wa_addr == i_rd_addr2))
      o_rd_data2 = i_wa_data;
    if (is_zero(i_rd_addr2))
      o_rd_data2 = '0;
  end

  // A returning load in the same cycle already resolves the hazard via bypass.
  assign o_rd_busy1 = r_pending[i_rd_addr1] & ~(i_wb_en & (i_wb_addr == i_rd_addr1))
                    & ~is_zero(i_rd_addr1);
  assign o_rd_busy2 = r_pending[i_rd_addr2] & ~(i_wb_en & (i_wb_addr == i_rd_addr2))
                    & ~is_zero(i_rd_addr2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_wa_ok && !w_ab_clash)
        r_mem[i_wa_addr] <= i_wa_data;
      if (w_wb_ok)
        r_mem[i_wb_addr] <= i_wb_data;
    end
  end

  // Mark is applied after clear so a new load issued as the old one returns keeps the bit set.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_ok)
      w_pending_nxt[i_wb_addr] = 1'b0;
    if (w_mark_ok)
      w_pending_nxt[i_mark_addr] = 1'b1;
  end

  assign w_cnt_inc = w_mark_ok & ~r_pending[i_mark_addr];
  assign w_cnt_dec = w_wb_ok & r_pending[i_wb_addr]
                   & ~(w_mark_ok & (i_mark_addr == i_wb_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= '0;
      r_pending_cnt <= '0;
      r_err         <= 2'b00;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_cnt_inc && !w_cnt_dec)
        r_pending_cnt <= r_pending_cnt + CNT_ONE;
      else if (w_cnt_dec && !w_cnt_inc)
        r_pending_cnt <= r_pending_cnt - CNT_ONE;
      r_err[0] <= r_err[0] | w_ab_clash;
      r_err[1] <= r_err[1] | (w_wa_ok & r_pending[i_wa_addr]);
    end
  end

  assign o_pending_cnt = r_pending_cnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_regbank_sb.sv
// Directed plus randomized bench for regbank_sb against an array/bit-vector reference model.
module tb_regbank_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_busy1, rd_busy2;
  logic          wa_en, wb_en, mark_en;
  logic [AW-1:0] wa_addr, wb_addr, mark_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic [AW:0]   pending_cnt;
  logic [1:0]    err;

  always #5 clk = ~clk;

  regbank_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rd_addr1   (rd_addr1),
    .i_rd_addr2   (rd_addr2),
    .o_rd_data1   (rd_data1),
    .o_rd_data2   (rd_data2),
    .o_rd_busy1   (rd_busy1),
    .o_rd_busy2   (rd_busy2),
    .i_wa_en      (wa_en),
    .i_wa_addr    (wa_addr),
    .i_wa_data    (wa_data),
    .i_wb_en      (wb_en),
    .i_wb_addr    (wb_addr),
    .i_wb_data    (wb_data),
    .i_mark_en    (mark_en),
    .i_mark_addr  (mark_addr),
    .o_pending_cnt(pending_cnt),
    .o_err        (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: register contents, set of outstanding loads, sticky error flags.
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  logic [1:0]       m_err;
  bit               m_valid = 1'b0;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  task automatic m_update();
    logic [DEPTH-1:0] old_pend;
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_pend  = '0;
      m_err   = 2'b00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      old_pend = m_pend;
      if (wa_en && wa_addr != 0 && old_pend[wa_addr]) m_err[1] = 1'b1;
      if (wa_en && wb_en && wa_addr == wb_addr && wa_addr != 0) m_err[0] = 1'b1;
      if (wa_en && wa_addr != 0 && !(wb_en && wb_addr == wa_addr)) m_mem[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) begin
        m_mem[wb_addr]  = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
    end
  endtask

  task automatic settle();
    #2;
    if (m_valid) begin
      check("rd_data1", rd_data1, m_read(rd_addr1));
      check("rd_data2", rd_data2, m_read(rd_addr2));
      check("rd_busy1", rd_busy1, m_busy(rd_addr1));
      check("rd_busy2", rd_busy2, m_busy(rd_addr2));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
    if (m_valid) begin
      check("pending_cnt", pending_cnt, $countones(m_pend));
      check("err", err, m_err);
    end
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; mark_en = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    reset = 1; rd_addr1 = 0; rd_addr2 = 0;
    wa_addr = 0; wb_addr = 0; mark_addr = 0; wa_data = 0; wb_data = 0;
    tick();
    reset = 0;
    check("rst_cnt", pending_cnt, 0);
    check("rst_err", err, 2'b00);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(DEPTH-1-i);
      settle();
      check("rst_rd1", rd_data1, 0);
      check("rst_busy1", rd_busy1, 0);
      tick();
    end

    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd_addr1 = 5;
    settle(); check("byp_r5", rd_data1, 32'hDEADBEEF);
    tick(); idle();
    settle(); check("arr_r5", rd_data1, 32'hDEADBEEF);
    tick();

    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF; rd_addr1 = 0;
    settle(); check("byp_r0", rd_data1, 0);
    tick(); idle();
    settle(); check("arr_r0", rd_data1, 0);
    tick();

    wa_en = 1; wa_addr = 7; wa_data = 32'h11; wb_en = 1; wb_addr = 7; wb_data = 32'h22; rd_addr1 = 7;
    settle(); check("ab_byp_r7", rd_data1, 32'h22);
    tick(); check("ab_err", err, 2'b01);
    idle();
    settle(); check("ab_arr_r7", rd_data1, 32'h22);
    tick();

    wa_en = 1; wa_addr = 3; wa_data = 32'h33; wb_en = 1; wb_addr = 4; wb_data = 32'h44;
    rd_addr1 = 3; rd_addr2 = 4;
    settle(); tick(); idle();
    settle();
    check("ab_r3", rd_data1, 32'h33);
    check("ab_r4", rd_data2, 32'h44);
    check("ab_err_kept", err, 2'b01);
    tick();

    mark_en = 1; mark_addr = 9; rd_addr1 = 9;
    settle(); check("mark_lat", rd_busy1, 0);
    tick(); idle();
    check("mark_cnt", pending_cnt, 1);
    settle(); check("mark_busy", rd_busy1, 1);
    wb_en = 1; wb_addr = 9; wb_data = 32'h55;
    settle();
    check("wb_busy", rd_busy1, 0);
    check("wb_data", rd_data1, 32'h55);
    tick(); idle();
    check("wb_cnt", pending_cnt, 0);

    mark_en = 1; mark_addr = 9;
    settle(); tick();
    wb_en = 1; wb_addr = 9; wb_data = 32'h66;
    settle(); tick(); idle();
    check("mw_cnt", pending_cnt, 1);
    settle();
    check("mw_data", rd_data1, 32'h66);
    check("mw_busy", rd_busy1, 1);
    wa_en = 1; wa_addr = 9; wa_data = 32'h77;
    settle(); tick(); idle();
    check("pend_err", err, 2'b11);
    settle(); check("pend_busy", rd_busy1, 1);

    for (int i = 1; i < DEPTH; i++) begin
      mark_en = 1; mark_addr = AW'(i);
      settle(); tick();
    end
    idle();
    check("all_cnt", pending_cnt, 31);
    reset = 1;
    settle(); tick();
    reset = 0;
    check("rst2_cnt", pending_cnt, 0);
    check("rst2_err", err, 2'b00);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(i);
      settle();
      check("rst2_rd", rd_data1, 0);
      check("rst2_busy", rd_busy2, 0);
      tick();
    end
    wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    settle(); tick(); idle();
    check("post_rst_wb_err", err, 2'b00);

    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      wa_en     = $urandom_range(0, 1) == 1;
      wb_en     = $urandom_range(0, 2) == 0;
      mark_en   = $urandom_range(0, 2) == 0;
      wa_addr   = rand_addr();
      wb_addr   = rand_addr();
      mark_addr = rand_addr();
      rd_addr1  = rand_addr();
      rd_addr2  = rand_addr();
      wa_data   = $urandom;
      wb_data   = $urandom;
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
